// File: rtl/l1a_sample_capture_if.sv
// Word-stream handshake from the event capture block toward the DAQ formatter.
// A word moves on any cycle where dout_vld and dout_rdy are both high.
interface l1a_sample_capture_if;
    logic [15:0] dout;
    logic        dout_vld;
    logic        dout_rdy;

    modport master (output dout, output dout_vld, input dout_rdy);
    modport slave  (input dout, input dout_vld, output dout_rdy);
endinterface

// File: rtl/l1a_sample_capture.sv
// Per-group L1A window capture: stores NSAMP pipeline rows per accepted trigger into
// one of NEVT slots and streams each stored event as header / data / trailer words.
//
// state    | meaning
// CAP_IDLE | waiting for an L1A while a slot is free
// CAP_RUN  | writing one pipeline row per cycle into the current write slot
// RD_IDLE  | nothing on DOUT; waiting for a complete event
// RD_HDR   | header word held on DOUT
// RD_DATA  | data word (r_samp, r_ch) held on DOUT
// RD_TRL   | trailer word held on DOUT; slot is freed when it is accepted
module l1a_sample_capture #(
    parameter int         NEVT   = 4,
    parameter logic [2:0] GRP_ID = 3'd0
) (
    input  logic                 i_rdclk,
    input  logic                 i_rst,
    input  logic                 i_l1a,
    input  logic [4:0]           i_nsamp,
    input  logic [191:0]         i_pipout,
    l1a_sample_capture_if.master o_dout_bus,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [3:0]           o_nevts,
    output logic [11:0]          o_l1a_cnt,
    output logic [7:0]           o_lost_cnt
);
    localparam int PW = $clog2(NEVT);

    typedef enum logic [0:0] {CAP_IDLE, CAP_RUN} cap_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_HDR, RD_DATA, RD_TRL} rd_state_t;

    cap_state_t r_cap_state;
    rd_state_t  r_rd_state;

    logic [15:0][11:0] r_mem [NEVT*16];
    logic [11:0]       r_meta_evt   [NEVT];
    logic [3:0]        r_meta_ns_m1 [NEVT];

    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [3:0]        r_wr_row;
    logic [3:0]        r_cap_ns_m1;
    logic [3:0]        r_nevts;
    logic [11:0]       r_l1a_cnt;
    logic [7:0]        r_lost_cnt;

    logic [15:0][11:0] r_row;
    logic [3:0]        r_samp;
    logic [3:0]        r_ch;
    logic [15:0]       r_dout;
    logic              r_vld;

    logic [3:0]        w_ns_m1;
    logic [3:0]        w_occ;
    logic              w_full;
    logic              w_drop;
    logic              w_accept;
    logic              w_cap_done;
    logic              w_trl_acc;
    logic [4:0]        w_rd_ns;
    logic [15:0]       w_trl;
    logic [3:0]        w_ch_nxt;
    logic [3:0]        w_samp_nxt;

    // Effective sample count minus one: 0 behaves as 1, anything above 16 as 16.
    always_comb begin
        w_ns_m1 = i_nsamp[3:0] - 4'd1;
        if (i_nsamp == 5'd0)
            w_ns_m1 = 4'd0;
        else if (i_nsamp[4])
            w_ns_m1 = 4'd15;
    end

    assign w_occ      = r_nevts + {3'b000, (r_cap_state == CAP_RUN)};
    assign w_full     = (w_occ == 4'(NEVT));
    assign w_drop     = (r_cap_state == CAP_RUN) || w_full;
    assign w_accept   = i_l1a && !w_drop && !i_rst;
    assign w_cap_done = (r_cap_state == CAP_RUN) && (r_wr_row == r_cap_ns_m1);
    assign w_trl_acc  = (r_rd_state == RD_TRL) && o_dout_bus.dout_rdy;
    assign w_rd_ns    = {1'b0, r_meta_ns_m1[r_rd_ptr]} + 5'd1;
    assign w_trl      = {4'hE, 1'b0, GRP_ID, 3'b000, w_rd_ns};
    assign w_ch_nxt   = r_ch + 4'd1;
    assign w_samp_nxt = r_samp + 4'd1;

    always_ff @(posedge i_rdclk) begin
        if (i_rst) begin
            r_cap_state <= CAP_IDLE;
            r_wr_ptr    <= '0;
            r_wr_row    <= 4'd0;
            r_cap_ns_m1 <= 4'd0;
        end else begin
            case (r_cap_state)
                CAP_IDLE: begin
                    if (w_accept) begin
                        r_cap_state <= CAP_RUN;
                        r_wr_row    <= 4'd0;
                        r_cap_ns_m1 <= w_ns_m1;
                    end
                end
                CAP_RUN: begin
                    r_wr_row <= r_wr_row + 4'd1;
                    if (w_cap_done) begin
                        r_cap_state <= CAP_IDLE;
                        r_wr_ptr    <= r_wr_ptr + PW'(1);
                    end
                end
                default: r_cap_state <= CAP_IDLE;
            endcase
        end
    end

    // Sample storage and slot metadata carry no reset; occupancy lives in r_nevts.
    always_ff @(posedge i_rdclk) begin
        if (r_cap_state == CAP_RUN)
            r_mem[{r_wr_ptr, r_wr_row}] <= i_pipout;
        if ((r_cap_state == CAP_IDLE) && w_accept) begin
            r_meta_evt[r_wr_ptr]   <= r_l1a_cnt + 12'd1;
            r_meta_ns_m1[r_wr_ptr] <= w_ns_m1;
        end
    end

    always_ff @(posedge i_rdclk) begin
        if (i_rst) begin
            r_l1a_cnt  <= 12'd0;
            r_lost_cnt <= 8'd0;
            r_nevts    <= 4'd0;
        end else begin
            if (i_l1a)
                r_l1a_cnt <= r_l1a_cnt + 12'd1;
            if (i_l1a && w_drop && (r_lost_cnt != 8'hFF))
                r_lost_cnt <= r_lost_cnt + 8'd1;
            r_nevts <= r_nevts + {3'b000, w_cap_done} - {3'b000, w_trl_acc};
        end
    end

    // The next row is fetched while channel 15 of the current row is loaded, so the
    // registered memory read never costs a bubble at a sample boundary.
    always_ff @(posedge i_rdclk) begin
        if (i_rst) begin
            r_rd_state <= RD_IDLE;
            r_rd_ptr   <= '0;
            r_row      <= '0;
            r_samp     <= 4'd0;
            r_ch       <= 4'd0;
            r_dout     <= 16'd0;
            r_vld      <= 1'b0;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    if (r_nevts != 4'd0) begin
                        r_dout     <= {4'hB, r_meta_evt[r_rd_ptr]};
                        r_vld      <= 1'b1;
                        r_row      <= r_mem[{r_rd_ptr, 4'd0}];
                        r_samp     <= 4'd0;
                        r_ch       <= 4'd0;
                        r_rd_state <= RD_HDR;
                    end
                end
                RD_HDR: begin
                    if (o_dout_bus.dout_rdy) begin
                        r_dout     <= {4'h0, r_row[0]};
                        r_ch       <= 4'd0;
                        r_rd_state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (o_dout_bus.dout_rdy) begin
                        if (r_ch == 4'd15) begin
                            if (r_samp == r_meta_ns_m1[r_rd_ptr]) begin
                                r_dout     <= w_trl;
                                r_rd_state <= RD_TRL;
                            end else begin
                                r_dout <= {4'h0, r_row[0]};
                                r_samp <= w_samp_nxt;
                                r_ch   <= 4'd0;
                            end
                        end else begin
                            r_dout <= {4'h0, r_row[w_ch_nxt]};
                            r_ch   <= w_ch_nxt;
                            if (w_ch_nxt == 4'd15)
                                r_row <= r_mem[{r_rd_ptr, w_samp_nxt}];
                        end
                    end
                end
                RD_TRL: begin
                    if (o_dout_bus.dout_rdy) begin
                        r_dout     <= 16'd0;
                        r_vld      <= 1'b0;
                        r_rd_ptr   <= r_rd_ptr + PW'(1);
                        r_rd_state <= RD_IDLE;
                    end
                end
                default: r_rd_state <= RD_IDLE;
            endcase
        end
    end

    assign o_dout_bus.dout     = r_dout;
    assign o_dout_bus.dout_vld = r_vld;
    assign o_full              = w_full;
    assign o_empty             = (r_nevts == 4'd0);
    assign o_nevts             = r_nevts;
    assign o_l1a_cnt           = r_l1a_cnt;
    assign o_lost_cnt          = r_lost_cnt;
endmodule

// File: tb/tb_l1a_sample_capture.sv
// Directed bench for l1a_sample_capture: ramp data, backpressure, overflow, overlap,
// NSAMP clamping and reset during readout, with hand-computed expected words.
module tb_l1a_sample_capture;
    logic         clk = 1'b0;
    logic         rst;
    logic         l1a;
    logic [4:0]   nsamp;
    logic [191:0] pipout;
    logic         full;
    logic         empty;
    logic [3:0]   nevts;
    logic [11:0]  l1a_cnt;
    logic [7:0]   lost_cnt;

    l1a_sample_capture_if u_if ();

    l1a_sample_capture #(.NEVT(4), .GRP_ID(3'd0)) dut (
        .i_rdclk    (clk),
        .i_rst      (rst),
        .i_l1a      (l1a),
        .i_nsamp    (nsamp),
        .i_pipout   (pipout),
        .o_dout_bus (u_if),
        .o_full     (full),
        .o_empty    (empty),
        .o_nevts    (nevts),
        .o_l1a_cnt  (l1a_cnt),
        .o_lost_cnt (lost_cnt)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] words [$];
    int          word_cyc [$];
    int          cyc = 0;
    int          ramp_k = 0;
    bit          rdy_rand = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] wd(input int i);
        if (i < words.size())
            return words[i];
        return 16'hxxxx;
    endfunction

    // Inputs change and outputs are observed at the falling edge only.
    task automatic step();
        logic        hold;
        logic [15:0] held;
        hold = u_if.dout_vld && !u_if.dout_rdy && !rst;
        held = u_if.dout;
        if (u_if.dout_vld && u_if.dout_rdy) begin
            words.push_back(u_if.dout);
            word_cyc.push_back(cyc);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (hold && !rst)
            check("hold_stable", {u_if.dout_vld, u_if.dout}, {1'b1, held});
        for (int c = 0; c < 16; c++)
            pipout[12*c +: 12] = 12'(16*ramp_k + c);
        ramp_k++;
        if (rdy_rand)
            u_if.dout_rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic fire(input bit restart);
        l1a = 1'b1;
        if (restart)
            ramp_k = 0;
        step();
        l1a = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        l1a = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        words.delete();
        word_cyc.delete();
    endtask

    task automatic collect(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while ((words.size() < n) && (k < budget)) begin
            step();
            k++;
        end
        repeat (20) step();
        check(tag, words.size(), n);
    endtask

    task automatic check_ramp_event(input string tag, input logic [11:0] evt);
        int span;
        check({tag, "_hdr"}, wd(0), {4'hB, evt});
        for (int i = 0; i < 128; i++)
            check({tag, "_data"}, wd(i + 1), 16'(i));
        check({tag, "_trl"}, wd(129), 16'hE008);
        span = (word_cyc.size() == 130) ? (word_cyc[129] - word_cyc[0]) : -1;
        if (!rdy_rand)
            check({tag, "_no_bubble"}, span, 129);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        l1a = 1'b0;
        nsamp = 5'd8;
        pipout = '0;
        u_if.dout_rdy = 1'b1;

        do_reset();
        check("rst_dout", u_if.dout, 16'h0000);
        check("rst_vld", u_if.dout_vld, 1'b0);
        check("rst_full", full, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_nevts", nevts, 4'd0);
        check("rst_l1a_cnt", l1a_cnt, 12'd0);
        check("rst_lost_cnt", lost_cnt, 8'd0);

        // Single event, ramp data, consumer always ready.
        nsamp = 5'd8;
        fire(1'b1);
        k = 0;
        while ((nevts == 4'd0) && (k < 50)) begin step(); k++; end
        check("nevts_rise", nevts, 4'd1);
        k = 0;
        while (!u_if.dout_vld && (k < 5)) begin step(); k++; end
        check("hdr_latency_le3", (k <= 3), 1'b1);
        collect(130, 400, "single_count");
        check_ramp_event("single", 12'd1);
        check("single_nevts_end", nevts, 4'd0);
        check("single_empty_end", empty, 1'b1);

        // Same event under random backpressure.
        do_reset();
        nsamp = 5'd8;
        rdy_rand = 1'b1;
        fire(1'b1);
        collect(130, 1500, "bp_count");
        check_ramp_event("bp", 12'd1);
        rdy_rand = 1'b0;
        u_if.dout_rdy = 1'b1;

        // Overflow: four slots fill, the last two triggers are lost.
        do_reset();
        u_if.dout_rdy = 1'b0;
        nsamp = 5'd4;
        for (int j = 0; j < 6; j++) begin
            fire(1'b1);
            repeat (9) step();
            if (j == 3) begin
                check("ovf_full_after4", full, 1'b1);
                check("ovf_lost_after4", lost_cnt, 8'd0);
            end
        end
        check("ovf_full", full, 1'b1);
        check("ovf_nevts", nevts, 4'd4);
        check("ovf_lost", lost_cnt, 8'd2);
        check("ovf_l1a_cnt", l1a_cnt, 12'd6);
        u_if.dout_rdy = 1'b1;
        collect(264, 800, "ovf_count");
        check("ovf_hdr1", wd(0), 16'hB001);
        check("ovf_hdr2", wd(66), 16'hB002);
        check("ovf_hdr3", wd(132), 16'hB003);
        check("ovf_hdr4", wd(198), 16'hB004);
        check("ovf_trl4", wd(263), 16'hE004);
        check("ovf_full_end", full, 1'b0);
        check("ovf_empty_end", empty, 1'b1);

        // Overlap: second trigger three cycles later falls inside the capture.
        do_reset();
        nsamp = 5'd8;
        fire(1'b1);
        step();
        step();
        fire(1'b0);
        collect(130, 400, "ovl_count");
        check("ovl_lost", lost_cnt, 8'd1);
        check("ovl_l1a_cnt", l1a_cnt, 12'd2);
        check_ramp_event("ovl", 12'd1);

        // Clamping of NSAMP = 0 and NSAMP = 31.
        do_reset();
        nsamp = 5'd0;
        fire(1'b1);
        collect(18, 200, "clamp0_count");
        check("clamp0_hdr", wd(0), 16'hB001);
        check("clamp0_first", wd(1), 16'h0000);
        check("clamp0_last", wd(16), 16'h000F);
        check("clamp0_trl", wd(17), 16'hE001);
        words.delete();
        word_cyc.delete();
        nsamp = 5'd31;
        fire(1'b1);
        collect(258, 600, "clamp31_count");
        check("clamp31_hdr", wd(0), 16'hB002);
        check("clamp31_mid", wd(129), 16'h0080);
        check("clamp31_last", wd(256), 16'h00FF);
        check("clamp31_trl", wd(257), 16'hE010);

        // Reset while data word 40 is on the bus.
        do_reset();
        nsamp = 5'd8;
        fire(1'b1);
        k = 0;
        while (!(u_if.dout_vld && (u_if.dout == 16'h0028)) && (k < 300)) begin
            step();
            k++;
        end
        check("mrst_reach_word40", {u_if.dout_vld, u_if.dout}, {1'b1, 16'h0028});
        rst = 1'b1;
        step();
        check("mrst_vld", u_if.dout_vld, 1'b0);
        check("mrst_nevts", nevts, 4'd0);
        check("mrst_l1a_cnt", l1a_cnt, 12'd0);
        check("mrst_lost_cnt", lost_cnt, 8'd0);
        check("mrst_empty", empty, 1'b1);
        rst = 1'b0;
        step();
        words.delete();
        word_cyc.delete();
        fire(1'b1);
        collect(130, 400, "mrst_count");
        check_ramp_event("mrst", 12'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
